// File: rtl/step_tracker_pkg.sv
// Shared display-mode encoding and saturating arithmetic helpers for the pedometer core.
package step_tracker_pkg;

  localparam logic [1:0] MODE_STEPS = 2'd0;
  localparam logic [1:0] MODE_DIST  = 2'd1;
  localparam logic [1:0] MODE_RUN   = 2'd2;
  localparam logic [1:0] MODE_HIGH  = 2'd3;

  // Callers widen to 64 bits and truncate back, so one helper serves every counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] max_v);
    logic [64:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[63:0];
  endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Two-flop synchroniser for the raw step input followed by a registered rising-edge detector.
module step_edge_sync (
  input  logic CLK,
  input  logic reset_n,
  input  logic pulse,
  output logic step_evt
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_evt;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_evt   <= 1'b0;
    end else begin
      r_sync1 <= pulse;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_evt   <= r_sync2 & ~r_prev;
    end
  end

  assign step_evt = r_evt;

endmodule

// File: rtl/step_tracker_core.sv
// Pedometer core: one-second tick, step/run/high-activity statistics and a saturating
// display mux whose mode auto-rotates or follows a manual selection.
module step_tracker_core
  import step_tracker_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int TOTAL_W       = 32,
  parameter int RATE_W        = 8,
  parameter int TIME_W        = 16,
  parameter int RUN_THRESH    = 32,
  parameter int HI_THRESH     = 64,
  parameter int HI_MIN_SEC    = 60,
  parameter int DIST_SHIFT    = 11,
  parameter int DISP_MAX      = 9999,
  parameter int ROTATE_SEC    = 2
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        pulse,
  input  logic        manual,
  input  logic [1:0]  mode_sel,
  output logic [15:0] display,
  output logic        decimal_point,
  output logic        SI,
  output logic [1:0]  mode,
  output logic        sec_tick
);

  localparam int DIV_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int ROT_W = $clog2(ROTATE_SEC + 1);
  localparam int VAL_W = TOTAL_W + 4;
  localparam logic [63:0] TOTAL_MAX = (64'd1 << TOTAL_W) - 64'd1;
  localparam logic [63:0] RATE_MAX  = (64'd1 << RATE_W) - 64'd1;
  localparam logic [63:0] TIME_MAX  = (64'd1 << TIME_W) - 64'd1;

  logic               w_step_evt;
  logic               w_tick;
  logic [DIV_W-1:0]   r_div;
  logic [ROT_W-1:0]   r_rot;
  logic [1:0]         r_mode;
  logic [TOTAL_W-1:0] r_total;
  logic [RATE_W-1:0]  r_win;
  logic [TIME_W-1:0]  r_cur_run;
  logic [TIME_W-1:0]  r_best_run;
  logic [TIME_W-1:0]  r_hi_run;
  logic [TIME_W-1:0]  r_hi_total;
  logic [RATE_W-1:0]  w_win_inc;
  logic [RATE_W-1:0]  w_rate_new;
  logic [TIME_W-1:0]  w_cur_inc;
  logic [TIME_W-1:0]  w_hi_inc;
  logic [TIME_W-1:0]  w_hi_sum;
  logic [VAL_W-1:0]   w_dist;
  logic [VAL_W-1:0]   w_val;

  step_edge_sync u_edge (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .pulse    (pulse),
    .step_evt (w_step_evt)
  );

  assign w_tick   = (32'(r_div) == TICKS_PER_SEC - 1);
  assign sec_tick = w_tick;
  assign mode     = r_mode;

  // A step landing on the tick cycle still belongs to the second that is closing.
  assign w_win_inc  = RATE_W'(sat_inc(64'(r_win), RATE_MAX));
  assign w_rate_new = w_step_evt ? w_win_inc : r_win;
  assign w_cur_inc  = TIME_W'(sat_inc(64'(r_cur_run), TIME_MAX));
  assign w_hi_inc   = TIME_W'(sat_inc(64'(r_hi_run), TIME_MAX));
  assign w_hi_sum   = TIME_W'(sat_add(64'(r_hi_total), 64'(r_hi_run), TIME_MAX));

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_rot  <= '0;
      r_mode <= MODE_STEPS;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (manual) begin
        r_mode <= mode_sel;
        r_rot  <= '0;
      end else if (w_tick) begin
        if (32'(r_rot) + 1 >= ROTATE_SEC) begin
          r_mode <= r_mode + 2'd1;
          r_rot  <= '0;
        end else begin
          r_rot <= r_rot + ROT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_total    <= '0;
      r_win      <= '0;
      r_cur_run  <= '0;
      r_best_run <= '0;
      r_hi_run   <= '0;
      r_hi_total <= '0;
    end else if (clear) begin
      r_total    <= '0;
      r_win      <= '0;
      r_cur_run  <= '0;
      r_best_run <= '0;
      r_hi_run   <= '0;
      r_hi_total <= '0;
    end else begin
      if (w_step_evt) begin
        r_total <= TOTAL_W'(sat_inc(64'(r_total), TOTAL_MAX));
      end
      if (w_tick) begin
        r_win <= '0;
        if (32'(w_rate_new) >= RUN_THRESH) begin
          r_cur_run <= w_cur_inc;
          if (w_cur_inc > r_best_run) begin
            r_best_run <= w_cur_inc;
          end
        end else begin
          r_cur_run <= '0;
        end
        // Only a finished high-activity run of sufficient length is credited.
        if (32'(w_rate_new) >= HI_THRESH) begin
          r_hi_run <= w_hi_inc;
        end else begin
          if (32'(r_hi_run) >= HI_MIN_SEC) begin
            r_hi_total <= w_hi_sum;
          end
          r_hi_run <= '0;
        end
      end else if (w_step_evt) begin
        r_win <= w_win_inc;
      end
    end
  end

  assign w_dist = (VAL_W'(r_total) * VAL_W'(10)) >> DIST_SHIFT;

  always_comb begin
    w_val         = '0;
    decimal_point = 1'b0;
    display       = '0;
    SI            = 1'b0;
    case (r_mode)
      MODE_STEPS: w_val = VAL_W'(r_total);
      MODE_DIST: begin
        w_val         = w_dist;
        decimal_point = 1'b1;
      end
      MODE_RUN:  w_val = VAL_W'(r_best_run);
      MODE_HIGH: w_val = VAL_W'(r_hi_total);
    endcase
    if (w_val > VAL_W'(DISP_MAX)) begin
      display = 16'(DISP_MAX);
      SI      = 1'b1;
    end else begin
      display = w_val[15:0];
    end
  end

endmodule

// File: doc/step_tracker_core.md
Name: step_tracker_core

Overview:
Parametrised next-generation pedometer core. It counts debounced step edges, derives per-second step rate, total steps, distance, longest sustained-rate run and accumulated high-activity time, and drives a 4-digit display path. Display mode either auto-rotates or is selected manually. It sits between the step-sensor input and the seven-segment driver.

Parameters:
TICKS_PER_SEC, 100000000, CLK cycles per one-second tick
TOTAL_W, 32, width of total step counter (saturating)
RATE_W, 8, width of per-second step counter (saturating)
TIME_W, 16, width of all seconds counters (saturating)
RUN_THRESH, 32, steps/s at or above which a sustained-rate run continues
HI_THRESH, 64, steps/s at or above which a second counts as high activity
HI_MIN_SEC, 60, minimum run length (s) credited to high-activity total
DIST_SHIFT, 11, log2 steps per distance unit (2048 steps/mile)
DISP_MAX, 9999, display saturation value
ROTATE_SEC, 2, seconds per display mode in auto-rotate

Ports:
CLK  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear of all statistics, tick divider kept
pulse  in  1  raw step input, asynchronous to CLK
manual  in  1  1 = mode taken from mode_sel, 0 = auto-rotate
mode_sel  in  2  manual display mode
display  out  16  binary value to display, at most DISP_MAX
decimal_point  out  1  1 when value is in tenths
SI  out  1  1 when the displayed value was saturated
mode  out  2  current display mode
sec_tick  out  1  one-cycle pulse each second

Behaviour:
- Reset (reset_n=0, asynchronous): all counters, mode and outputs are 0; synchroniser flops are 0.
- pulse passes through a 2-flop synchroniser, then rising-edge detect. step_evt is one cycle per 0->1 transition, latency 3 cycles. A level held high counts once.
- Tick divider counts 0..TICKS_PER_SEC-1. sec_tick=1 in the cycle where the divider equals TICKS_PER_SEC-1, then the divider wraps to 0.
- total_steps increments on step_evt and saturates at 2^TOTAL_W-1.
- win_cnt increments on step_evt and saturates at 2^RATE_W-1.
- On sec_tick: rate <= win_cnt (+1 if step_evt in the same cycle, saturating). win_cnt <= 0. A step on the tick cycle belongs to the closing second.
- Run tracking is evaluated on each sec_tick using the new rate:
  - rate>=RUN_THRESH: cur_run+1 (saturating). best_run <= max(best_run, cur_run+1) in the same tick.
  - otherwise: cur_run <= 0.
- High activity is evaluated on each sec_tick:
  - rate>=HI_THRESH: hi_run+1 (saturating).
  - otherwise: if hi_run>=HI_MIN_SEC, hi_total += hi_run (saturating at 2^TIME_W-1); hi_run <= 0.
  - A run still in progress is not shown in hi_total.
- Auto-rotate: rot_cnt counts sec_ticks. On reaching ROTATE_SEC, mode <= mode+1 (wraps 3->0) and rot_cnt <= 0.
- Manual mode: mode <= mode_sel, registered, 1-cycle latency; rot_cnt is held at 0. Returning to auto resumes from the current mode.
- Display is a combinational mux of registered stats on mode, with saturation v>DISP_MAX -> display=DISP_MAX, SI=1:
  - 0: total_steps, decimal_point=0.
  - 1: (total_steps*10)>>DIST_SHIFT in tenths, decimal_point=1. Intermediate is TOTAL_W+4 bits, no overflow.
  - 2: best_run seconds, decimal_point=0.
  - 3: hi_total seconds, decimal_point=0.
- clear=1: zeroes total_steps, win_cnt, rate, cur_run, best_run, hi_run and hi_total. The tick divider and mode are unaffected. clear wins over a simultaneous step_evt or sec_tick.
- Reset mid-run: everything returns to 0 immediately; there is no partial credit to hi_total.

Decomposition:
- Package step_tracker_pkg holds the mode encoding constants MODE_STEPS=0, MODE_DIST=1, MODE_RUN=2, MODE_HIGH=3, plus the saturating-increment and saturating-add functions.
- One sub-module: step_edge_sync, covering the synchroniser and edge detector (in: CLK, reset_n, pulse; out: step_evt).
- Tick divider, statistics and display mux stay inline.

Test Plan:
- Reset: assert reset_n=0 mid-operation -> display=0, SI=0, decimal_point=0, mode=0 within the same cycle; releasing it gives the first sec_tick TICKS_PER_SEC cycles later.
- Edge counting (TICKS_PER_SEC=200, manual=1, mode_sel=0): 5 pulses each high 3 cycles, plus one pulse held high 50 cycles -> display=6, SI=0.
- Saturation/distance: 10000 pulses with mode_sel=0 -> display=9999, SI=1. With mode_sel=1 -> display=(10000*10)>>11=48, decimal_point=1.
- Runs: rate 40/s for 4 s, then 10/s, then 40/s for 3 s, with mode_sel=2 -> display=4 after the first run and still 4 after the second.
- High activity (HI_MIN_SEC=3): 64/s for 2 s then 0 -> hi_total=0. Then 70/s for 3 s then 0 -> display=3 in mode 3. A step on the tick cycle is counted in that second's rate.
- Auto-rotate/clear: manual=0, ROTATE_SEC=2 -> mode sequence 0,1,2,3,0 every 2 s. clear pulsed together with step_evt -> total_steps=0, mode unchanged.
